// File: rtl/rpsc_pkg.sv
// Shared RPSC definitions: CA sequencer state encoding and counter sizing helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rpsc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WARM  = 3'd2,
    READY = 3'd3,
    TRIP  = 3'd4
  } ca_state_e;

  // Counter width able to hold max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-time counter: counts while enabled, saturates at the terminal value, flags done.
// Latency: done is combinational from the registered count; clear/increment take effect on the next edge.
// Backpressure: none; clr overrides en, and counting stops at term so the count never wraps.
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = (cnt == term);

  // Count up while enabled, hold at the terminal value, restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ca_interlock_seq.sv
// CA supply interlock: IDLE -> ARM -> WARM -> READY sequencing with latched, acknowledged trip.
// Latency: every output changes on the clock edge after the input that causes it.
// Backpressure: none; all inputs are level-sensitive and sampled every cycle.
module ca_interlock_seq
  import rpsc_pkg::*;
#(
  parameter int                 N_FAULT    = 7,
  parameter logic [N_FAULT-1:0] FAULT_MASK = '0,
  parameter int                 ARM_TICKS  = 256,
  parameter int                 WARM_TICKS = 3840
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_FAULT-1:0] fault_in,
  input  logic               g1_ok,
  input  logic               fan_ok,
  input  logic               ps_req,
  input  logic               i_high,
  input  logic               u_low,
  input  logic               ack,
  output logic               not_alarm,
  output logic               ca_permit,
  output logic               ca_on,
  output logic               ca_ready,
  output logic               not_ca_ok,
  output logic               i_high_trip,
  output logic               u_low_trip,
  output logic [N_FAULT+1:0] first_fault,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_ARM   = ARM;
  localparam logic [2:0] S_WARM  = WARM;
  localparam logic [2:0] S_READY = READY;
  localparam logic [2:0] S_TRIP  = TRIP;

  localparam int             CW        = cnt_width(ARM_TICKS, WARM_TICKS);
  localparam logic [CW-1:0]  ARM_TERM  = CW'(ARM_TICKS - 1);
  localparam logic [CW-1:0]  WARM_TERM = CW'(WARM_TICKS - 1);

  logic [2:0]         state_q;
  logic [2:0]         next_state;
  logic [N_FAULT-1:0] fault_act;
  logic               flt;
  logic               permit;
  logic               mon_en;
  logic               mon;
  logic               drop;
  logic               cnt_clr;
  logic               cnt_en;
  logic [CW-1:0]      cnt_term;
  logic               cnt_done;
  logic               trip_enter;
  logic               trip_exit;
  logic               not_alarm_q;
  logic               i_high_trip_q;
  logic               u_low_trip_q;
  logic [N_FAULT+1:0] first_fault_q;

  assign fault_act = fault_in & ~FAULT_MASK;
  assign flt       = |fault_act;
  assign permit    = ~flt & g1_ok & fan_ok;
  // Over-current / under-voltage only mean something once the supply is energised.
  assign mon_en    = (state_q == S_WARM) || (state_q == S_READY);
  assign mon       = mon_en & (i_high | u_low);
  assign drop      = ~g1_ok | ~fan_ok | ~ps_req;

  // Next-state decode; within each state trip beats drop beats count complete.
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE: begin
        if (permit && ps_req) next_state = S_ARM;
      end
      S_ARM: begin
        if (flt)           next_state = S_TRIP;
        else if (drop)     next_state = S_IDLE;
        else if (cnt_done) next_state = S_WARM;
      end
      S_WARM: begin
        if (flt || mon)    next_state = S_TRIP;
        else if (drop)     next_state = S_IDLE;
        else if (cnt_done) next_state = S_READY;
      end
      S_READY: begin
        if (flt || mon)    next_state = S_TRIP;
        else if (drop)     next_state = S_IDLE;
      end
      S_TRIP: begin
        if (ack && !flt && !ps_req) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // One shared timer, reloaded with the hold time of whichever state is active.
  assign cnt_clr  = (next_state != state_q);
  assign cnt_en   = (state_q == S_ARM) || (state_q == S_WARM);
  assign cnt_term = (state_q == S_WARM) ? WARM_TERM : ARM_TERM;

  hold_timer #(
    .W (CW)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term),
    .done  (cnt_done)
  );

  assign trip_enter = (next_state == S_TRIP) && (state_q != S_TRIP);
  assign trip_exit  = (state_q == S_TRIP) && (next_state != S_TRIP);

  // State register plus registered alarm, so not_alarm tracks the same edge as state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      not_alarm_q <= 1'b1;
    end else begin
      state_q     <= next_state;
      not_alarm_q <= ~(flt | (next_state == S_TRIP));
    end
  end

  // First-fault snapshot and sticky monitor flags: load on trip entry, hold, clear on exit.
  always_ff @(posedge clk) begin
    if (reset || trip_exit) begin
      first_fault_q <= '0;
      i_high_trip_q <= 1'b0;
      u_low_trip_q  <= 1'b0;
    end else if (trip_enter) begin
      first_fault_q <= {u_low & mon_en, i_high & mon_en, fault_act};
      i_high_trip_q <= i_high & mon_en;
      u_low_trip_q  <= u_low & mon_en;
    end
  end

  assign state       = state_q;
  assign not_alarm   = not_alarm_q;
  assign ca_permit   = (state_q == S_ARM) || (state_q == S_WARM) || (state_q == S_READY);
  assign ca_on       = (state_q == S_WARM) || (state_q == S_READY);
  assign ca_ready    = (state_q == S_READY);
  assign not_ca_ok   = ~ca_ready;
  assign i_high_trip = i_high_trip_q;
  assign u_low_trip  = u_low_trip_q;
  assign first_fault = first_fault_q;

endmodule

// File: tb/tb_ca_interlock_seq.sv
// Directed bench for ca_interlock_seq with ARM_TICKS=4, WARM_TICKS=8, N_FAULT=7, fault bit 0 masked.
// Latency: inputs are driven 1 ns after a rising edge, outputs checked 1 ns after the next one.
// Backpressure: n/a.
module tb_ca_interlock_seq;

  localparam int N_FAULT = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_FAULT-1:0] fault_in;
  logic               g1_ok, fan_ok, ps_req, i_high, u_low, ack;
  logic               not_alarm, ca_permit, ca_on, ca_ready, not_ca_ok;
  logic               i_high_trip, u_low_trip;
  logic [N_FAULT+1:0] first_fault;
  logic [2:0]         state;

  int n_chk  = 0;
  int n_fail = 0;

  ca_interlock_seq #(
    .N_FAULT    (N_FAULT),
    .FAULT_MASK (7'b0000001),
    .ARM_TICKS  (4),
    .WARM_TICKS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fault_in    (fault_in),
    .g1_ok       (g1_ok),
    .fan_ok      (fan_ok),
    .ps_req      (ps_req),
    .i_high      (i_high),
    .u_low       (u_low),
    .ack         (ack),
    .not_alarm   (not_alarm),
    .ca_permit   (ca_permit),
    .ca_on       (ca_on),
    .ca_ready    (ca_ready),
    .not_ca_ok   (not_ca_ok),
    .i_high_trip (i_high_trip),
    .u_low_trip  (u_low_trip),
    .first_fault (first_fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle_vals(input string tag);
    chk({tag, ".state"},     32'(state), 0);
    chk({tag, ".permit"},    32'(ca_permit), 0);
    chk({tag, ".on"},        32'(ca_on), 0);
    chk({tag, ".ready"},     32'(ca_ready), 0);
    chk({tag, ".not_ca_ok"}, 32'(not_ca_ok), 1);
    chk({tag, ".not_alarm"}, 32'(not_alarm), 1);
    chk({tag, ".ff"},        32'(first_fault), 0);
    chk({tag, ".ih_trip"},   32'(i_high_trip), 0);
    chk({tag, ".ul_trip"},   32'(u_low_trip), 0);
  endtask

  initial begin
    reset = 1'b1; fault_in = '0; g1_ok = 1'b0; fan_ok = 1'b0;
    ps_req = 1'b0; i_high = 1'b0; u_low = 1'b0; ack = 1'b0;
    tick(2);
    chk_idle_vals("reset");

    // 1/3a/5b: clean start, i_high ignored in ARM, masked fault ignored
    reset = 1'b0; g1_ok = 1'b1; fan_ok = 1'b1; ps_req = 1'b1;   // cycle 0
    tick(1);                                                     // cycle 1
    chk("c1.state", 32'(state), 1);
    chk("c1.permit", 32'(ca_permit), 1);
    chk("c1.on", 32'(ca_on), 0);
    i_high = 1'b1;
    tick(1);                                                     // cycle 2
    fault_in = 7'b0000001;
    tick(1);                                                     // cycle 3
    chk("c3.masked_alarm", 32'(not_alarm), 1);
    chk("c3.state", 32'(state), 1);
    tick(1);                                                     // cycle 4
    chk("c4.arm_mon_gated", 32'(state), 1);
    tick(1);                                                     // cycle 5
    i_high = 1'b0;
    chk("c5.state", 32'(state), 2);
    chk("c5.on", 32'(ca_on), 1);
    chk("c5.ready", 32'(ca_ready), 0);
    tick(7);                                                     // cycle 12
    chk("c12.ready", 32'(ca_ready), 0);
    tick(1);                                                     // cycle 13
    chk("c13.state", 32'(state), 3);
    chk("c13.ready", 32'(ca_ready), 1);
    chk("c13.not_ca_ok", 32'(not_ca_ok), 0);

    // 3b: over-current in READY trips
    i_high = 1'b1;
    tick(1);
    i_high = 1'b0;
    chk("rdy_ih.state", 32'(state), 4);
    chk("rdy_ih.ih_trip", 32'(i_high_trip), 1);
    chk("rdy_ih.ul_trip", 32'(u_low_trip), 0);
    chk("rdy_ih.ff", 32'(first_fault), 'h080);
    chk("rdy_ih.not_alarm", 32'(not_alarm), 0);
    chk("rdy_ih.permit", 32'(ca_permit), 0);
    chk("rdy_ih.not_ca_ok", 32'(not_ca_ok), 1);

    // 4: acknowledge rules
    fault_in = '0; ack = 1'b1;                 // ps_req still 1
    tick(1);
    chk("ack_psreq.state", 32'(state), 4);
    ps_req = 1'b0; fault_in = 7'b0000100;
    tick(1);
    chk("ack_flt.state", 32'(state), 4);
    chk("ack_flt.ff_hold", 32'(first_fault), 'h080);
    chk("ack_flt.not_alarm", 32'(not_alarm), 0);
    fault_in = '0;
    tick(1);
    ack = 1'b0;
    chk_idle_vals("ack_ok");

    // 2: unmasked fault in WARM at cycle 7
    ps_req = 1'b1;                             // cycle 0
    tick(7);                                   // cycle 7
    chk("w7.state", 32'(state), 2);
    fault_in = 7'b0000100;
    tick(1);                                   // cycle 8
    chk("w8.state", 32'(state), 4);
    chk("w8.ff", 32'(first_fault), 'h004);
    chk("w8.permit", 32'(ca_permit), 0);
    chk("w8.on", 32'(ca_on), 0);
    chk("w8.ready", 32'(ca_ready), 0);
    chk("w8.not_alarm", 32'(not_alarm), 0);
    chk("w8.ih_trip", 32'(i_high_trip), 0);
    fault_in = '0; ps_req = 1'b0; ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("w_clr.state", 32'(state), 0);

    // under-voltage in WARM
    ps_req = 1'b1;
    tick(5);
    chk("ul.warm", 32'(state), 2);
    u_low = 1'b1;
    tick(1);
    u_low = 1'b0;
    chk("ul.state", 32'(state), 4);
    chk("ul.ul_trip", 32'(u_low_trip), 1);
    chk("ul.ih_trip", 32'(i_high_trip), 0);
    chk("ul.ff", 32'(first_fault), 'h100);
    ps_req = 1'b0; ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk_idle_vals("ul_clr");

    // 5a: fan drop in ARM, then re-arm with a fresh count
    ps_req = 1'b1;                             // cycle 0
    tick(2);                                   // cycle 2
    chk("drop.arm", 32'(state), 1);
    fan_ok = 1'b0;
    tick(1);                                   // cycle 3
    chk_idle_vals("drop");
    fan_ok = 1'b1;
    tick(1);                                   // cycle 4
    chk("rearm.state", 32'(state), 1);
    tick(3);                                   // cycle 7
    chk("rearm.c7", 32'(state), 1);
    tick(1);                                   // cycle 8
    chk("rearm.c8", 32'(state), 2);

    // 6: reset while in WARM returns everything to reset values
    tick(1);
    reset = 1'b1;
    tick(1);
    chk_idle_vals("midrst");
    reset = 1'b0; ps_req = 1'b0;
    tick(1);
    chk("post_rst.state", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ca_interlock_seq.md
# ca_interlock_seq

Parametrised cathode (CA) supply interlock card for the RPSC control chain. It is the successor to the fixed-width, shift-register-delayed CA card. It sequences the CA supply through an arm delay and a warm-up delay using counters. Any permit fault latches a trip, with a first-fault snapshot, and the trip clears only on an explicit acknowledge. It sits between the status/sensor input conditioning and the CA power-supply drive outputs.

## Interface
- N_FAULT, 7: number of status fault inputs (card position, air grid, water anode, water grid, DC PS, U low, I high, …); must be ≥ 1.
- FAULT_MASK, '0: N_FAULT-bit mask; a set bit ignores that fault input entirely.
- ARM_TICKS, 256: cycles spent in ARM; must be ≥ 1.
- WARM_TICKS, 3840: cycles spent in WARM; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fault_in  in  N_FAULT  active-high status faults, already synchronised to clk.
- g1_ok  in  1  grid-1 supply healthy.
- fan_ok  in  1  cooling fan running.
- ps_req  in  1  CA supply on request, level-sensitive.
- i_high  in  1  CA over-current monitor, active-high.
- u_low  in  1  CA under-voltage monitor, active-high.
- ack  in  1  operator trip acknowledge, level-sensitive.
- not_alarm  out  1  low when any unmasked fault is active or the state is TRIP.
- ca_permit  out  1  high in ARM, WARM and READY.
- ca_on  out  1  high in WARM and READY.
- ca_ready  out  1  high in READY only.
- not_ca_ok  out  1  equals ~ca_ready.
- i_high_trip  out  1  sticky; the trip was caused by i_high.
- u_low_trip  out  1  sticky; the trip was caused by u_low.
- first_fault  out  N_FAULT+2  snapshot on trip entry: {u_low, i_high, unmasked fault_in}.
- state  out  3  current state encoding, for diagnostics.

## Operation
Definitions:
- flt = |(fault_in & ~FAULT_MASK).
- permit = ~flt & g1_ok & fan_ok.
- mon = i_high | u_low. The monitors are honoured only in WARM and READY.

States: IDLE, ARM, WARM, READY, TRIP. Evaluation priority within a state is trip > drop > count complete.
- IDLE → ARM when permit & ps_req. A fault in IDLE does not trip; it only drives not_alarm low.
- ARM:
  - flt → TRIP.
  - Otherwise ~g1_ok | ~fan_ok | ~ps_req → IDLE.
  - Otherwise, when the counter reaches ARM_TICKS-1 → WARM.
- WARM:
  - flt | mon → TRIP.
  - Otherwise a drop of g1_ok, fan_ok or ps_req → IDLE.
  - Otherwise, when the counter reaches WARM_TICKS-1 → READY.
- READY:
  - flt | mon → TRIP.
  - A drop of g1_ok, fan_ok or ps_req → IDLE.
- TRIP → IDLE only when ack & ~flt & ~ps_req are all true in the same cycle. Otherwise the block holds in TRIP.

Trip latching:
- On entry to TRIP, first_fault, i_high_trip and u_low_trip load from the inputs of the cycle that caused the trip.
- Monitor bits load only if the trip came from WARM or READY.
- All three hold until TRIP exits, then clear to 0.

Counter behaviour:
- The counter clears on every state change and otherwise increments in ARM and WARM.
- Width is $clog2(max(ARM_TICKS, WARM_TICKS)). The counter never wraps.

## Timing
Reset values:
- State = IDLE, counter = 0, first_fault = 0, sticky flags = 0.
- ca_permit = ca_on = ca_ready = 0.
- not_ca_ok = 1, not_alarm = 1.

Output timing:
- All outputs are registered or decoded from registered state. Each output changes on the edge after the causing input.
- With permit & ps_req sampled at edge 0:
  - ARM is visible after edge 1.
  - WARM after edge 1+ARM_TICKS.
  - READY after edge 1+ARM_TICKS+WARM_TICKS.
- not_alarm is registered: ~(flt | next_state==TRIP).
- If flt and ack are sampled in the same cycle while in TRIP, the block stays in TRIP.
- If reset is asserted mid-sequence, the block returns to the IDLE reset values on that edge, regardless of ack.

## Structure
- The shared package rpsc_pkg holds the ca_state_e enum, 3-bit encoded as IDLE=0, ARM=1, WARM=2, READY=3, TRIP=4.
- One sub-module, hold_timer, contains the counter with clear, enable, terminal value and done output. It is instanced once and reloaded per state.

## Test plan
Bench parameters for all scenarios: ARM_TICKS=4, WARM_TICKS=8, N_FAULT=7.
1. Clean start:
   - Stimulus: permit, ps_req=1 at cycle 0.
   - Response: ca_permit=1 at cycle 1, ca_on=1 at cycle 5, ca_ready=1 and not_ca_ok=0 at cycle 13.
2. Fault in WARM:
   - Stimulus: fault_in=7'b0000100 at cycle 7.
   - Response: state=TRIP at cycle 8, first_fault=9'b000000100, all drive outputs 0, not_alarm=0.
3. Monitor gating:
   - Stimulus: i_high=1 during ARM.
   - Response: no trip.
   - Stimulus: i_high=1 in READY.
   - Response: TRIP, i_high_trip=1, first_fault[7]=1.
4. Acknowledge rules:
   - Stimulus: ack with ps_req=1, or with the fault still present.
   - Response: stays in TRIP.
   - Stimulus: ack=1, flt=0, ps_req=0.
   - Response: IDLE next cycle, sticky flags and first_fault cleared.
5. Drop without fault:
   - Stimulus: fan_ok=0 in ARM.
   - Response: IDLE next cycle, no trip, counter restarts on re-arm.
   - Stimulus: FAULT_MASK=7'b0000001 with fault_in[0]=1.
   - Response: ignored.
6. Mid-sequence reset:
   - Stimulus: reset=1 at cycle 10 while in WARM.
   - Response: all reset values at cycle 11.
